// File: rtl/regs_writeback.sv
// regs_writeback: merges ALU results and in-order load returns onto the register file write port
// Ports: clock/reset (sync, active-high); alu_valid/alu_rd/alu_data -> alu_ready;
// ld_issue/ld_rd -> ld_ready; mem_valid/mem_data (in issue order, unstallable);
// RegEscr/DadoEscr/EscReg drive the register file; pending = per-register in-flight write; err sticky.
module regs_writeback #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [ADDR_W-1:0]    ld_rd,
  output logic                 ld_ready,
  input  logic                 mem_valid,
  input  logic [DATA_W-1:0]    mem_data,
  output logic [ADDR_W-1:0]    RegEscr,
  output logic [DATA_W-1:0]    DadoEscr,
  output logic                 EscReg,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] r_q [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;
  logic              r_hv;
  logic [ADDR_W-1:0] r_hrd;
  logic [DATA_W-1:0] r_hd;
  logic              w_empty, w_full, w_pop, w_push, w_acc, w_wv;
  logic [ADDR_W-1:0] w_wrd;
  logic [DATA_W-1:0] w_wd;
  logic [PW-1:0]     w_off;
  assign w_empty   = r_cnt == '0;
  assign w_full    = r_cnt == CW'(DEPTH);
  assign ld_ready  = !w_full;
  assign alu_ready = !r_hv;
  assign w_pop     = mem_valid && !w_empty;
  // a pop in the same cycle frees the slot, so a full queue still takes the push
  assign w_push    = ld_issue && (!w_full || w_pop);
  assign w_acc     = alu_valid && !r_hv;
  assign w_wv      = w_pop || r_hv || w_acc;
  assign w_wrd     = w_pop ? r_q[r_rp] : r_hv ? r_hrd : alu_rd;
  assign w_wd      = w_pop ? mem_data : r_hv ? r_hd : alu_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_hv     <= 1'b0;
      r_hrd    <= '0;
      r_hd     <= '0;
      err      <= 1'b0;
      EscReg   <= 1'b0;
      RegEscr  <= '0;
      DadoEscr <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= ld_rd;
        r_wp      <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      // hold survives only while load returns keep winning the port
      r_hv <= w_pop && (r_hv || w_acc);
      if (w_pop && w_acc) begin
        r_hrd <= alu_rd;
        r_hd  <= alu_data;
      end
      err      <= err || (ld_issue && w_full && !w_pop) || (mem_valid && w_empty);
      EscReg   <= w_wv && (w_wrd != '0);
      RegEscr  <= w_wrd;
      DadoEscr <= w_wd;
    end
  end
  always_comb begin
    pending = '0;
    w_off   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_off = PW'(k) - r_rp;
      if (CW'(w_off) < r_cnt) pending[r_q[k]] = 1'b1;
    end
    if (r_hv) pending[r_hrd] = 1'b1;
    if (EscReg) pending[RegEscr] = 1'b1;
    pending[0] = 1'b0;
  end
endmodule

// File: doc/regs_writeback.md
# regs_writeback

Write-side controller for the 8-bit nRISC register file. It merges ALU results and in-order load returns from data memory onto the file's single write port (RegEscr/DadoEscr/EscReg). It also keeps a per-register pending scoreboard that decode uses to stall on reads of not-yet-written registers. It sits between the execute/memory stages and the register file and is the only driver of the file's write port.

## Interface
- DATA_W, 8, data width; must match register file width
- ADDR_W, 3, register index width (8 registers, r0 hard-wired zero)
- DEPTH, 4, max outstanding loads (load queue entries); power of two, >= 2
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- alu_valid  in  1  ALU result offered this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU offer is accepted when alu_valid && alu_ready
- ld_issue  in  1  load issued to memory this cycle
- ld_rd  in  ADDR_W  destination of the issued load
- ld_ready  out  1  load queue has a free entry
- mem_valid  in  1  load data returning; in issue order, cannot be stalled
- mem_data  in  DATA_W  returned load data
- RegEscr  out  ADDR_W  write address to register file
- DadoEscr  out  DATA_W  write data to register file
- EscReg  out  1  write enable to register file
- pending  out  2**ADDR_W  bit i = register i has an uncommitted write in flight
- err  out  1  sticky protocol error flag

## Operation
- Load queue: FIFO of DEPTH entries holding rd only; occupancy count 0..DEPTH.
  - Push on ld_issue && ld_ready.
  - Pop on mem_valid && count>0.
  - Push and pop in the same cycle are allowed at any occupancy, including full; count stays unchanged.
  - Empty + mem_valid + ld_issue: pop is invalid, the push still happens, and err is set. There is no bypass.
- err is set by:
  - ld_issue while full with no simultaneous pop (the load is dropped);
  - mem_valid while count==0 (the data is dropped).
- err is cleared only by reset.
- Hold register: one entry {rd,data,valid} for an ALU result that lost arbitration.
- alu_ready = !hold_valid (registered state, not combinational on mem_valid).
- Per-cycle arbitration for the output stage, highest priority first:
  1. Load return (mem_valid && count>0): output {head rd, mem_data}.
  2. Hold register valid: output hold, clear hold.
  3. Accepted ALU offer: output {alu_rd, alu_data}.
  4. Otherwise EscReg=0 next cycle.
- If an ALU offer is accepted but a load return wins, the offer goes into the hold register.
- If the hold register is already occupied, no offer is accepted (alu_ready=0).
- Output stage is registered: RegEscr/DadoEscr/EscReg are updated every posedge from the winner.
- Any winner with rd==0 produces EscReg=0. The load is still popped and the ALU offer is still consumed.
- pending[i], i!=0, is the OR of:
  - any valid queue entry with rd==i;
  - hold valid with rd==i;
  - EscReg==1 && RegEscr==i.
- pending[0] is always 0. pending is combinational from registered state only.
- WAW ordering (an ALU write to a register with a pending load) is prevented by decode stalling on pending. This block does not reorder writes.
- Reset: queue emptied, hold cleared, output stage cleared, err cleared. Mid-operation reset discards all in-flight writes. Memory returns arriving after reset with an empty queue set err.

## Timing
- Reset values:
  - EscReg=0, RegEscr=0, DadoEscr=0;
  - pending=0, err=0;
  - alu_ready=1, ld_ready=1.
- Latency from input to write:
  - Load return at edge n: EscReg=1 from edge n until edge n+1; the register file commits at edge n+1.
  - Uncontended ALU accept at edge n: same timing as a load return.
- Contended ALU result: hold at edge n, output at the first later edge with no load return.
- Scoreboard timing:
  - pending bit rises after the ld_issue edge.
  - It falls after the edge where the register file commits the write, so there is never a gap in which decode reads stale data.
- ld_ready = (count<DEPTH), from registered count.
- Throughput: one register write per cycle. Sustained back-to-back load returns starve the ALU path; alu_ready stays 0 while the hold register is occupied.

## Test plan
- Reset, then ALU offer {rd=3, data=0x0A} at edge 1 → EscReg=1, RegEscr=3, DadoEscr=0x0A during cycle 1–2; pending[3] high for exactly that cycle; alu_ready stays 1.
- ld_issue rd=5, rd=6 at edges 1 and 2; mem_valid data 0x11 at edge 4, 0x22 at edge 5 → writes r5=0x11 then r6=0x22. pending[5] high from after edge 1 to edge 5; pending[6] high from after edge 2 to edge 6.
- Same-edge mem_valid (load to r2, 0x33) and ALU {r4, 0x44} → r2=0x33 written first. alu_ready=0 for one cycle. r4=0x44 written next cycle. pending[4] high throughout.
- Fill DEPTH=4 loads: ld_ready falls. A 5th ld_issue sets err and pending is unchanged. Then simultaneous ld_issue+mem_valid while full → count stays 4, err unchanged.
- ALU offer to r0 and load to r0 → EscReg stays 0, pending[0] stays 0, load queue pops normally.
- Reset asserted with 3 loads queued and hold valid → next cycle pending=0, ld_ready=1, EscReg=0. A stray mem_valid afterwards sets err.
